// File: rtl/gen_pipe_dff.sv
`default_nettype none
// ==========================================================================
// gen_pipe_dff: DEPTH-stage elastic valid/ready register chain. Rev 1.0
// ==========================================================================
module gen_pipe_dff #(
   parameter int            DW      = 32,
   parameter int            DEPTH   = 2,
   parameter logic [DW-1:0] RST_VAL = {DW{1'b0}},
   parameter int            CW      = $clog2(DEPTH+1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [CW-1:0] count
);

   logic [DEPTH-1:0] v;
   logic [DW-1:0]    d [DEPTH];
   logic [DEPTH-1:0] adv;
   logic             in_fire;
   logic             out_fire;

   // A stage may advance if it is empty or the stage after it advances.
   always_comb begin
      logic run;
      run = out_ready || !v[DEPTH-1];
      adv[DEPTH-1] = run;
      for (int i = DEPTH-2; i >= 0; i--) begin
         run    = !v[i] || run;
         adv[i] = run;
      end
   end

   assign in_ready  = adv[0] && !flush;
   assign out_valid = v[DEPTH-1] && !flush;
   assign out_data  = d[DEPTH-1];
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         v     <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            d[i] <= RST_VAL;
         end
      end else if (flush) begin
         v     <= '0;
         count <= '0;
      end else begin
         count <= count + CW'(in_fire) - CW'(out_fire);
         if (adv[0]) begin
            v[0] <= in_fire;
         end
         if (in_fire) begin
            d[0] <= in_data;
         end
         // Data registers only move with a valid beat, so bubbles never toggle them.
         for (int i = 1; i < DEPTH; i++) begin
            if (adv[i]) begin
               v[i] <= v[i-1];
               if (v[i-1]) begin
                  d[i] <= d[i-1];
               end
            end
         end
      end
   end

endmodule
`default_nettype wire
